// File: rtl/lsb_queue_param_if.sv
// lsb_queue_param_if
//   Bundles every non-clock/reset signal of the load/store queue.
//   master : surrounding core + memory controller (dispatch, wakeup, commit,
//            roll-back, memory completion)
//   slave  : the load/store queue itself (occupancy, memory request, load result)
interface lsb_queue_param_if #(
  parameter int IDX_W   = 4,
  parameter int ROB_W   = 4,
  parameter int NUM_CDB = 2
);
  logic                     rdy_in;
  logic                     roll_back;
  logic                     de_en;
  logic                     de_st;
  logic [2:0]               de_op;
  logic [31:0]              de_vj;
  logic [31:0]              de_vk;
  logic                     de_qj_en;
  logic                     de_qk_en;
  logic [ROB_W-1:0]         de_qj;
  logic [ROB_W-1:0]         de_qk;
  logic [31:0]              de_off;
  logic [ROB_W-1:0]         de_rob;
  logic [NUM_CDB-1:0]       cdb_en;
  logic [NUM_CDB*ROB_W-1:0] cdb_rob;
  logic [NUM_CDB*32-1:0]    cdb_val;
  logic                     cmt_en;
  logic [ROB_W-1:0]         cmt_rob;
  logic                     full;
  logic [IDX_W:0]           count;
  logic                     mem_req;
  logic                     mem_we;
  logic [1:0]               mem_type;
  logic [31:0]              mem_addr;
  logic [31:0]              mem_wdata;
  logic                     mem_done;
  logic [31:0]              mem_rdata;
  logic                     res_en;
  logic [ROB_W-1:0]         res_rob;
  logic [31:0]              res_val;

  modport master (
    output rdy_in, roll_back, de_en, de_st, de_op, de_vj, de_vk, de_qj_en, de_qk_en,
           de_qj, de_qk, de_off, de_rob, cdb_en, cdb_rob, cdb_val, cmt_en, cmt_rob,
           mem_done, mem_rdata,
    input  full, count, mem_req, mem_we, mem_type, mem_addr, mem_wdata,
           res_en, res_rob, res_val
  );

  modport slave (
    input  rdy_in, roll_back, de_en, de_st, de_op, de_vj, de_vk, de_qj_en, de_qk_en,
           de_qj, de_qk, de_off, de_rob, cdb_en, cdb_rob, cdb_val, cmt_en, cmt_rob,
           mem_done, mem_rdata,
    output full, count, mem_req, mem_we, mem_type, mem_addr, mem_wdata,
           res_en, res_rob, res_val
  );
endinterface

// File: rtl/lsb_queue_param.sv
// lsb_queue_param
//   In-order load/store queue for the out-of-order core. Entries are dispatched
//   at the rear, woken up by the CDB broadcast ports, marked committed by the
//   ROB and issued from the front to the memory controller one at a time.
//   Ports:
//     clk     system clock
//     rst_in  asynchronous active-high reset
//     bus     lsb_queue_param_if.slave (dispatch, wakeup, commit, roll-back,
//             occupancy, memory req/done handshake, load result)

// Protocol checker: dispatching into a full queue is only legal while the head pops.
module lsb_queue_param_chk (
  input logic clk,
  input logic rst,
  input logic rdy,
  input logic roll_back,
  input logic de_en,
  input logic full,
  input logic pop
);
  a_no_dispatch_when_full: assert property (
    @(posedge clk) disable iff (rst) (rdy && !roll_back && de_en && full) |-> pop
  ) else $error("dispatch while queue full");
endmodule

module lsb_queue_param #(
  parameter int         DEPTH   = 16,
  parameter int         IDX_W   = 4,
  parameter int         ROB_W   = 4,
  parameter int         NUM_CDB = 2,
  parameter logic [1:0] IO_HI   = 2'b11
) (
  input logic              clk,
  input logic              rst_in,
  lsb_queue_param_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'b00, WAIT_MEM = 2'b01, FLUSH = 2'b10} state_t;

  localparam logic [IDX_W:0]   DEPTH_C = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   CNT_ONE = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  // Lowest-numbered matching port wins, hence the descending scan.
  function automatic logic [32:0] cdb_pick(
    input logic [ROB_W-1:0]         tag,
    input logic [NUM_CDB-1:0]       en,
    input logic [NUM_CDB*ROB_W-1:0] robs,
    input logic [NUM_CDB*32-1:0]    vals
  );
    logic [32:0] r;
    r = 33'd0;
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (en[p] && (robs[p*ROB_W +: ROB_W] == tag)) begin
        r = {1'b1, vals[p*32 +: 32]};
      end
    end
    return r;
  endfunction

  function automatic logic [1:0] op_type(input logic [2:0] op);
    case (op)
      3'd0, 3'd3: op_type = 2'b01;
      3'd1, 3'd4: op_type = 2'b10;
      3'd2:       op_type = 2'b11;
      default:    op_type = 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] d);
    case (op)
      3'd0:    extend = {{24{d[7]}}, d[7:0]};
      3'd1:    extend = {{16{d[15]}}, d[15:0]};
      3'd3:    extend = {24'd0, d[7:0]};
      3'd4:    extend = {16'd0, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  // Entry storage
  logic             busy  [DEPTH];
  logic             cmtd  [DEPTH];
  logic             st    [DEPTH];
  logic [2:0]       op    [DEPTH];
  logic [31:0]      vj    [DEPTH];
  logic [31:0]      vk    [DEPTH];
  logic             qj_en [DEPTH];
  logic             qk_en [DEPTH];
  logic [ROB_W-1:0] qj    [DEPTH];
  logic [ROB_W-1:0] qk    [DEPTH];
  logic [31:0]      off   [DEPTH];
  logic [ROB_W-1:0] rob   [DEPTH];

  logic [IDX_W-1:0] front;
  logic [IDX_W-1:0] rear;
  logic [IDX_W:0]   cnt;
  state_t           state;
  state_t           next_state;

  // Latched memory-side registers
  logic             req;
  logic             we;
  logic [1:0]       mtype;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic [2:0]       cur_op;
  logic [ROB_W-1:0] cur_rob;

  logic             is_full;
  logic [31:0]      head_addr;
  logic             head_ok;
  logic             issue;
  logic             done_ok;
  logic             res_fire;
  logic             accept;
  logic [32:0]      de_hit_j;
  logic [32:0]      de_hit_k;
  logic [DEPTH-1:0] wake_j;
  logic [DEPTH-1:0] wake_k;
  logic [31:0]      wval_j [DEPTH];
  logic [31:0]      wval_k [DEPTH];
  logic [DEPTH-1:0] keep;
  logic [IDX_W:0]   kept;
  logic [IDX_W:0]   cnt_next;

  assign is_full   = (cnt == DEPTH_C);
  assign head_addr = vj[front] + off[front];
  assign de_hit_j  = cdb_pick(bus.de_qj, bus.cdb_en, bus.cdb_rob, bus.cdb_val);
  assign de_hit_k  = cdb_pick(bus.de_qk, bus.cdb_en, bus.cdb_rob, bus.cdb_val);

  // Head may go to memory once operands are ready and it is either committed or a non-IO load.
  always_comb begin
    head_ok = busy[front] && !qj_en[front] && !qk_en[front] &&
              (cmtd[front] || (!st[front] && (head_addr[17:16] != IO_HI)));
  end

  // Per-entry CDB match against every broadcast port.
  always_comb begin
    logic [32:0] hj;
    logic [32:0] hk;
    hj = 33'd0;
    hk = 33'd0;
    for (int i = 0; i < DEPTH; i++) begin
      hj        = cdb_pick(qj[i], bus.cdb_en, bus.cdb_rob, bus.cdb_val);
      hk        = cdb_pick(qk[i], bus.cdb_en, bus.cdb_rob, bus.cdb_val);
      wake_j[i] = busy[i] && qj_en[i] && hj[32];
      wake_k[i] = busy[i] && qk_en[i] && hk[32];
      wval_j[i] = hj[31:0];
      wval_k[i] = hk[31:0];
    end
  end

  // Roll-back survivors: the run of committed stores starting at front.
  always_comb begin
    logic             run;
    logic [IDX_W-1:0] idx;
    keep = '0;
    kept = '0;
    run  = 1'b1;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = front + IDX_W'(i);
      if (run && busy[idx] && cmtd[idx] && st[idx]) begin
        keep[idx] = 1'b1;
        kept      = kept + CNT_ONE;
      end else begin
        run = 1'b0;
      end
    end
  end

  // FSM next-state and handshake decode.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    done_ok    = 1'b0;
    res_fire   = 1'b0;
    if (bus.rdy_in) begin
      case (state)
        IDLE: begin
          if (head_ok && !bus.roll_back) begin
            issue      = 1'b1;
            next_state = WAIT_MEM;
          end else begin
            next_state = IDLE;
          end
        end
        WAIT_MEM: begin
          if (bus.mem_done) begin
            done_ok    = 1'b1;
            res_fire   = !we;
            next_state = IDLE;
          end else if (bus.roll_back && !we) begin
            next_state = FLUSH;
          end else begin
            next_state = WAIT_MEM;
          end
        end
        FLUSH: begin
          if (bus.mem_done) begin
            done_ok    = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = FLUSH;
          end
        end
        default: next_state = IDLE;
      endcase
    end else begin
      next_state = state;
    end
  end

  // A full queue still accepts a dispatch in the cycle its head pops.
  always_comb begin
    accept   = bus.rdy_in && !bus.roll_back && bus.de_en && (!is_full || issue);
    cnt_next = cnt;
    if (accept && !issue) begin
      cnt_next = cnt + CNT_ONE;
    end else if (issue && !accept) begin
      cnt_next = cnt - CNT_ONE;
    end else begin
      cnt_next = cnt;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Queue storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      front <= '0;
      rear  <= '0;
      cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        busy[i]  <= 1'b0;
        cmtd[i]  <= 1'b0;
        st[i]    <= 1'b0;
        op[i]    <= 3'd0;
        vj[i]    <= 32'd0;
        vk[i]    <= 32'd0;
        qj_en[i] <= 1'b0;
        qk_en[i] <= 1'b0;
        qj[i]    <= '0;
        qk[i]    <= '0;
        off[i]   <= 32'd0;
        rob[i]   <= '0;
      end
    end else if (bus.rdy_in) begin
      if (bus.roll_back) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!keep[i]) begin
            busy[i] <= 1'b0;
            cmtd[i] <= 1'b0;
          end
        end
        rear <= front + kept[IDX_W-1:0];
        cnt  <= kept;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wake_j[i]) begin
            qj_en[i] <= 1'b0;
            vj[i]    <= wval_j[i];
          end
          if (wake_k[i]) begin
            qk_en[i] <= 1'b0;
            vk[i]    <= wval_k[i];
          end
          if (bus.cmt_en && busy[i] && (rob[i] == bus.cmt_rob)) begin
            cmtd[i] <= 1'b1;
          end
        end
        // Pop before dispatch so a full-queue refill of the same slot wins.
        if (issue) begin
          busy[front] <= 1'b0;
          cmtd[front] <= 1'b0;
          front       <= front + IDX_ONE;
        end
        if (accept) begin
          busy[rear]  <= 1'b1;
          cmtd[rear]  <= 1'b0;
          st[rear]    <= bus.de_st;
          op[rear]    <= bus.de_op;
          off[rear]   <= bus.de_off;
          rob[rear]   <= bus.de_rob;
          qj[rear]    <= bus.de_qj;
          qk[rear]    <= bus.de_qk;
          qj_en[rear] <= bus.de_qj_en && !de_hit_j[32];
          qk_en[rear] <= bus.de_qk_en && !de_hit_k[32];
          vj[rear]    <= (bus.de_qj_en && de_hit_j[32]) ? de_hit_j[31:0] : bus.de_vj;
          vk[rear]    <= (bus.de_qk_en && de_hit_k[32]) ? de_hit_k[31:0] : bus.de_vk;
          rear        <= rear + IDX_ONE;
        end
        cnt <= cnt_next;
      end
    end
  end

  // Memory request registers: latched on issue, dropped after completion.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      req     <= 1'b0;
      we      <= 1'b0;
      mtype   <= 2'b00;
      addr    <= 32'd0;
      wdata   <= 32'd0;
      cur_op  <= 3'd0;
      cur_rob <= '0;
    end else if (issue) begin
      req     <= 1'b1;
      we      <= st[front];
      mtype   <= op_type(op[front]);
      addr    <= head_addr;
      wdata   <= vk[front];
      cur_op  <= op[front];
      cur_rob <= rob[front];
    end else if (done_ok) begin
      req   <= 1'b0;
      mtype <= 2'b00;
    end
  end

  assign bus.full      = is_full;
  assign bus.count     = cnt;
  assign bus.mem_req   = req;
  assign bus.mem_we    = we;
  assign bus.mem_type  = mtype;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.res_en    = res_fire;
  assign bus.res_rob   = cur_rob;
  assign bus.res_val   = res_fire ? extend(cur_op, bus.mem_rdata) : 32'd0;

  lsb_queue_param_chk u_chk (
    .clk       (clk),
    .rst       (rst_in),
    .rdy       (bus.rdy_in),
    .roll_back (bus.roll_back),
    .de_en     (bus.de_en),
    .full      (is_full),
    .pop       (issue)
  );

endmodule

// File: tb/tb_lsb_queue_param.sv
// tb_lsb_queue_param
//   Directed bench for lsb_queue_param: a table of load vectors (width and
//   extension), then hand-written sequences for store wakeup/commit, full
//   queue with pop+dispatch and wrap, roll-back with flush, IO load, freeze
//   and mid-operation reset.
module tb_lsb_queue_param;

  logic clk = 1'b0;
  logic rst_in;
  int   n_checks = 0;
  int   n_fail   = 0;

  lsb_queue_param_if #(.IDX_W(4), .ROB_W(4), .NUM_CDB(2)) bus ();

  lsb_queue_param #(.DEPTH(16), .IDX_W(4), .ROB_W(4), .NUM_CDB(2), .IO_HI(2'b11)) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] vj;
    logic [31:0] off;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [1:0]  exp_type;
    logic [31:0] exp_val;
  } ld_vec_t;

  ld_vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic dispatch(input logic st, input logic [2:0] op, input logic [31:0] vj,
                          input logic [31:0] vk, input logic [31:0] off, input logic [3:0] rob,
                          input logic qj_en, input logic [3:0] qj,
                          input logic qk_en, input logic [3:0] qk);
    bus.de_en    = 1'b1;
    bus.de_st    = st;
    bus.de_op    = op;
    bus.de_vj    = vj;
    bus.de_vk    = vk;
    bus.de_off   = off;
    bus.de_rob   = rob;
    bus.de_qj_en = qj_en;
    bus.de_qj    = qj;
    bus.de_qk_en = qk_en;
    bus.de_qk    = qk;
    tick();
    bus.de_en    = 1'b0;
  endtask

  task automatic commit(input logic [3:0] rob);
    bus.cmt_en  = 1'b1;
    bus.cmt_rob = rob;
    tick();
    bus.cmt_en  = 1'b0;
  endtask

  // Bounded wait for mem_req; an expired bound shows up as a failed comparison.
  task automatic wait_req(input string name);
    for (int i = 0; i < 20 && !bus.mem_req; i++) tick();
    check(name, {31'd0, bus.mem_req}, 32'd1);
  endtask

  task automatic complete(input string name, input logic [31:0] rdata, input logic exp_res,
                          input logic [31:0] exp_val, input logic [3:0] exp_rob);
    bus.mem_done  = 1'b1;
    bus.mem_rdata = rdata;
    #1;
    check({name, "_res_en"}, {31'd0, bus.res_en}, {31'd0, exp_res});
    if (exp_res) begin
      check({name, "_res_val"}, bus.res_val, exp_val);
      check({name, "_res_rob"}, {28'd0, bus.res_rob}, {28'd0, exp_rob});
    end
    tick();
    bus.mem_done = 1'b0;
    #1;
    check({name, "_res_drop"}, {31'd0, bus.res_en}, 32'd0);
    check({name, "_req_drop"}, {31'd0, bus.mem_req}, 32'd0);
    check({name, "_type_none"}, {30'd0, bus.mem_type}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'd2, 32'h0000_0100, 32'h0000_0004, 32'h8000_00FF, 32'h0000_0104, 2'b11, 32'h8000_00FF};
    vecs[1] = '{3'd0, 32'h0000_0200, 32'h0000_0001, 32'h0000_0080, 32'h0000_0201, 2'b01, 32'hFFFF_FF80};
    vecs[2] = '{3'd3, 32'h0000_0200, 32'h0000_0002, 32'h0000_0080, 32'h0000_0202, 2'b01, 32'h0000_0080};
    vecs[3] = '{3'd1, 32'h0000_1000, 32'hFFFF_FFFE, 32'h0001_8001, 32'h0000_0FFE, 2'b10, 32'hFFFF_8001};
    vecs[4] = '{3'd4, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_8001, 32'h0000_0002, 2'b10, 32'h0000_8001};

    rst_in        = 1'b1;
    bus.rdy_in    = 1'b1;
    bus.roll_back = 1'b0;
    bus.de_en     = 1'b0;
    bus.de_st     = 1'b0;
    bus.de_op     = 3'd0;
    bus.de_vj     = 32'd0;
    bus.de_vk     = 32'd0;
    bus.de_qj_en  = 1'b0;
    bus.de_qk_en  = 1'b0;
    bus.de_qj     = 4'd0;
    bus.de_qk     = 4'd0;
    bus.de_off    = 32'd0;
    bus.de_rob    = 4'd0;
    bus.cdb_en    = 2'b00;
    bus.cdb_rob   = 8'd0;
    bus.cdb_val   = 64'd0;
    bus.cmt_en    = 1'b0;
    bus.cmt_rob   = 4'd0;
    bus.mem_done  = 1'b0;
    bus.mem_rdata = 32'd0;
    tick();
    tick();
    rst_in = 1'b0;
    tick();

    check("rst_count",   {27'd0, bus.count}, 32'd0);
    check("rst_full",    {31'd0, bus.full}, 32'd0);
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_type",    {30'd0, bus.mem_type}, 32'd0);
    check("rst_res_en",  {31'd0, bus.res_en}, 32'd0);

    // Ready loads: address, width and result extension.
    for (int i = 0; i < 5; i++) begin
      dispatch(1'b0, vecs[i].op, vecs[i].vj, 32'd0, vecs[i].off, 4'(i + 1),
               1'b0, 4'd0, 1'b0, 4'd0);
      wait_req($sformatf("ld%0d_req", i));
      check($sformatf("ld%0d_addr", i), bus.mem_addr, vecs[i].exp_addr);
      check($sformatf("ld%0d_type", i), {30'd0, bus.mem_type}, {30'd0, vecs[i].exp_type});
      check($sformatf("ld%0d_we", i), {31'd0, bus.mem_we}, 32'd0);
      complete($sformatf("ld%0d", i), vecs[i].rdata, 1'b1, vecs[i].exp_val, 4'(i + 1));
    end

    // Store waiting on qk=3, woken by CDB port 1, held until commit.
    dispatch(1'b1, 3'd2, 32'h0000_0040, 32'd0, 32'd0, 4'd6, 1'b0, 4'd0, 1'b1, 4'd3);
    bus.cdb_en  = 2'b11;
    bus.cdb_rob = {4'd3, 4'd9};
    bus.cdb_val = {32'h0000_DEAD, 32'h1234_5678};
    tick();
    bus.cdb_en  = 2'b00;
    for (int i = 0; i < 3; i++) begin
      check("st_no_issue_before_cmt", {31'd0, bus.mem_req}, 32'd0);
      tick();
    end
    commit(4'd6);
    wait_req("st_req");
    check("st_we",    {31'd0, bus.mem_we}, 32'd1);
    check("st_wdata", bus.mem_wdata, 32'h0000_DEAD);
    check("st_addr",  bus.mem_addr, 32'h0000_0040);
    complete("st", 32'd0, 1'b0, 32'd0, 4'd0);

    // Fill all 16 slots with uncommitted stores; the ring wraps past index 15.
    for (int i = 0; i < 16; i++) begin
      dispatch(1'b1, 3'd2, 32'(i * 4), 32'hA000_0000 + 32'(i), 32'd0, 4'(i),
               1'b0, 4'd0, 1'b0, 4'd0);
    end
    check("fill_count", {27'd0, bus.count}, 32'd16);
    check("fill_full",  {31'd0, bus.full}, 32'd1);
    check("fill_no_req", {31'd0, bus.mem_req}, 32'd0);
    commit(4'd0);
    // Head pops this cycle while a new store lands in the freed slot.
    dispatch(1'b1, 3'd2, 32'h0000_0040, 32'hA000_0010, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    check("popdisp_count", {27'd0, bus.count}, 32'd16);
    check("popdisp_full",  {31'd0, bus.full}, 32'd1);
    check("popdisp_req",   {31'd0, bus.mem_req}, 32'd1);
    check("popdisp_wdata", bus.mem_wdata, 32'hA000_0000);
    complete("popdisp", 32'd0, 1'b0, 32'd0, 4'd0);
    for (int k = 1; k <= 16; k++) begin
      commit(4'(k % 16));
      wait_req($sformatf("drain%0d_req", k));
      check($sformatf("drain%0d_wdata", k), bus.mem_wdata, 32'hA000_0000 + 32'(k));
      check($sformatf("drain%0d_addr", k), bus.mem_addr, 32'(k * 4));
      complete($sformatf("drain%0d", k), 32'd0, 1'b0, 32'd0, 4'd0);
    end
    check("drain_count", {27'd0, bus.count}, 32'd0);

    // Load in flight, two committed stores + three pending loads, then roll-back.
    dispatch(1'b0, 3'd2, 32'h0000_0500, 32'd0, 32'd0, 4'd7, 1'b0, 4'd0, 1'b0, 4'd0);
    wait_req("rb_ld_req");
    dispatch(1'b1, 3'd2, 32'h0000_0600, 32'h1111_1111, 32'd0, 4'd1, 1'b0, 4'd0, 1'b0, 4'd0);
    dispatch(1'b1, 3'd2, 32'h0000_0604, 32'h2222_2222, 32'd0, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      dispatch(1'b0, 3'd2, 32'd0, 32'd0, 32'd0, 4'(3 + i), 1'b1, 4'd12, 1'b0, 4'd0);
    end
    commit(4'd1);
    commit(4'd2);
    check("rb_pre_count", {27'd0, bus.count}, 32'd5);
    bus.roll_back = 1'b1;
    // This dispatch coincides with roll-back and must be dropped.
    dispatch(1'b0, 3'd2, 32'd0, 32'd0, 32'd0, 4'd9, 1'b0, 4'd0, 1'b0, 4'd0);
    bus.roll_back = 1'b0;
    check("rb_count",    {27'd0, bus.count}, 32'd2);
    check("rb_req_hold", {31'd0, bus.mem_req}, 32'd1);
    complete("rb_flush", 32'h0000_1234, 1'b0, 32'd0, 4'd0);
    wait_req("rb_st1_req");
    check("rb_st1_wdata", bus.mem_wdata, 32'h1111_1111);
    check("rb_st1_addr",  bus.mem_addr, 32'h0000_0600);
    complete("rb_st1", 32'd0, 1'b0, 32'd0, 4'd0);
    wait_req("rb_st2_req");
    check("rb_st2_wdata", bus.mem_wdata, 32'h2222_2222);
    complete("rb_st2", 32'd0, 1'b0, 32'd0, 4'd0);
    check("rb_end_count", {27'd0, bus.count}, 32'd0);

    // IO load waits for commit; a commit while frozen is not seen.
    dispatch(1'b0, 3'd2, 32'h0003_0000, 32'd0, 32'd0, 4'd8, 1'b0, 4'd0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      check("io_no_issue", {31'd0, bus.mem_req}, 32'd0);
      tick();
    end
    bus.rdy_in = 1'b0;
    commit(4'd8);
    bus.rdy_in = 1'b1;
    tick();
    tick();
    check("io_frozen_commit", {31'd0, bus.mem_req}, 32'd0);
    check("io_count", {27'd0, bus.count}, 32'd1);
    commit(4'd8);
    wait_req("io_req");
    check("io_addr", bus.mem_addr, 32'h0003_0000);
    complete("io", 32'h0000_0055, 1'b1, 32'h0000_0055, 4'd8);

    // Reset in the middle of an access abandons it.
    dispatch(1'b0, 3'd2, 32'h0000_0700, 32'd0, 32'd0, 4'd10, 1'b0, 4'd0, 1'b0, 4'd0);
    dispatch(1'b0, 3'd2, 32'h0000_0704, 32'd0, 32'd0, 4'd11, 1'b0, 4'd12, 1'b1, 4'd12);
    wait_req("mid_req");
    rst_in = 1'b1;
    #1;
    check("mid_rst_req",   {31'd0, bus.mem_req}, 32'd0);
    check("mid_rst_count", {27'd0, bus.count}, 32'd0);
    tick();
    rst_in = 1'b0;
    tick();
    tick();
    check("post_rst_req", {31'd0, bus.mem_req}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
